// File: rtl/zigzag_encryption.sv
// rtl/zigzag_encryption.sv - rail-fence encryption engine; buffers plaintext, emits it in rail order then the token
// Optional sticky overflow flag ovf_o when ZIGZAG_ENC_OVF_EN is defined.
module zigzag_encryption #(
    parameter int                 D_WIDTH         = 8,
    parameter int                 KEY_WIDTH       = 8,
    parameter int                 MAX_NOF_CHARS   = 50,
    parameter logic [D_WIDTH-1:0] START_ENC_TOKEN = 8'hFA
) (
    input  logic                 clk_sys,
    input  logic                 rst,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] key,
    output logic                 busy,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o
`ifdef ZIGZAG_ENC_OVF_EN
    ,
    output logic                 ovf_o
`endif
);

    localparam int IW = $clog2(2 * MAX_NOF_CHARS) + 1;
    localparam int CW = $clog2(MAX_NOF_CHARS + 1);
    localparam int AW = (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_NOF_CHARS);

    typedef enum logic [1:0] {COLLECT, EMIT, TOKEN} state_t;

    state_t              state, state_nxt;
    logic [D_WIDTH-1:0]  mem [MAX_NOF_CHARS];
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       k_q, rail, idx;
    logic                phase, fin;

    logic                tok_hit, byte_hit;
    logic [IW-1:0]       k_new, kc, w_rail, w_idx, n_items, p_len;
    logic [IW-1:0]       s_a, s_b, s0, s1, step, cand;
    logic [IW-1:0]       n_rail, n_idx;
    logic                w_phase, n_phase, n_done;

    assign tok_hit  = valid_i && (data_i == START_ENC_TOKEN);
    assign byte_hit = valid_i && (data_i != START_ENC_TOKEN);

    always_comb begin
        if (key == '0)
            k_new = IW'(1);
        else if (32'(key) > 32'(MAX_NOF_CHARS))
            k_new = IW'(MAX_NOF_CHARS);
        else
            k_new = IW'(key);
    end

    // On the token cycle index 0 is emitted directly, so the walker starts
    // from rail 0 / index 0 with the freshly clamped key.
    always_comb begin
        kc      = (state == COLLECT) ? k_new : k_q;
        w_rail  = (state == COLLECT) ? '0 : rail;
        w_idx   = (state == COLLECT) ? '0 : idx;
        w_phase = (state == COLLECT) ? 1'b0 : phase;
        n_items = IW'(cnt);
        p_len   = (kc - IW'(1)) << 1;
        s_b     = w_rail << 1;
        s_a     = p_len - s_b;
        s0      = w_phase ? s_b : s_a;
        s1      = w_phase ? s_a : s_b;
        step    = (kc == IW'(1)) ? IW'(1) : ((s0 != '0) ? s0 : s1);
        cand    = w_idx + step;
        if (cand < n_items) begin
            n_rail  = w_rail;
            n_idx   = cand;
            n_phase = ~w_phase;
            n_done  = 1'b0;
        end else begin
            n_rail  = w_rail + IW'(1);
            n_idx   = w_rail + IW'(1);
            n_phase = 1'b0;
            n_done  = (n_rail >= kc) || (n_rail >= n_items);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (tok_hit) state_nxt = (cnt == '0) ? TOKEN : EMIT;
            EMIT:    if (fin) state_nxt = TOKEN;
            TOKEN:   state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst)
            state <= COLLECT;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk_sys) begin
        if (state == COLLECT && byte_hit && cnt < MAX_CNT)
            mem[cnt[AW-1:0]] <= data_i;
    end

    // Outputs are registered on the same edge that changes state, so busy
    // and valid_o cover exactly the N+1 output cycles.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            data_o  <= '0;
            valid_o <= 1'b0;
            busy    <= 1'b0;
            cnt     <= '0;
            k_q     <= IW'(1);
            rail    <= '0;
            idx     <= '0;
            phase   <= 1'b0;
            fin     <= 1'b0;
`ifdef ZIGZAG_ENC_OVF_EN
            ovf_o   <= 1'b0;
`endif
        end else begin
            case (state)
                COLLECT: begin
                    valid_o <= 1'b0;
                    busy    <= 1'b0;
                    if (tok_hit) begin
                        k_q     <= k_new;
                        rail    <= n_rail;
                        idx     <= n_idx;
                        phase   <= n_phase;
                        fin     <= n_done;
                        valid_o <= 1'b1;
                        busy    <= 1'b1;
                        data_o  <= (cnt == '0) ? START_ENC_TOKEN : mem[0];
                    end else if (byte_hit && cnt < MAX_CNT) begin
                        cnt <= cnt + CW'(1);
                    end
`ifdef ZIGZAG_ENC_OVF_EN
                    else if (byte_hit) begin
                        ovf_o <= 1'b1;
                    end
`endif
                end
                EMIT: begin
                    valid_o <= 1'b1;
                    busy    <= 1'b1;
                    if (fin) begin
                        data_o <= START_ENC_TOKEN;
                    end else begin
                        data_o <= mem[idx[AW-1:0]];
                        rail   <= n_rail;
                        idx    <= n_idx;
                        phase  <= n_phase;
                        fin    <= n_done;
                    end
                end
                TOKEN: begin
                    valid_o <= 1'b0;
                    busy    <= 1'b0;
                    cnt     <= '0;
`ifdef ZIGZAG_ENC_OVF_EN
                    ovf_o   <= 1'b0;
`endif
                end
                default: begin
                    valid_o <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
